// File: rtl/fifo_sync_param_pkg.sv
// Shared definitions for the parametrised synchronous FIFO: default geometry,
// read-mode encodings and the word-count update classification.
package fifo_sync_param_pkg;

    localparam int unsigned DefDataWidth = 8;
    localparam int unsigned DefAddrWidth = 4;

    // Read-mode encodings for the FWFT parameter.
    localparam int unsigned ModeStd  = 0;
    localparam int unsigned ModeFwft = 1;

    // Bit order is {read accepted, write accepted}.
    typedef enum logic [1:0] {
        OpIdle  = 2'b00,
        OpWrite = 2'b01,
        OpRead  = 2'b10,
        OpBoth  = 2'b11
    } cnt_op_e;

    function automatic cnt_op_e cnt_op(input logic wr_acc, input logic rd_acc);
        return cnt_op_e'({rd_acc, wr_acc});
    endfunction

endpackage

// File: rtl/reg_file_dp_param.sv
// Dual-port register file: one synchronous write port and one registered,
// enable-gated read port. Storage is not reset; only the read register is.
module reg_file_dp_param
    import fifo_sync_param_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned ADDR_WIDTH = DefAddrWidth
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [Depth];
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Write port.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Registered read port; holds its value while not enabled.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with standard or first-word-fall-through read,
// programmable almost-full/almost-empty thresholds, synchronous flush and sticky
// overflow/underflow flags. Legal parameters: 1 <= AE_THRESH < AF_THRESH <= DEPTH-1,
// ADDR_WIDTH >= 2.
module fifo_sync_param
    import fifo_sync_param_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned ADDR_WIDTH = DefAddrWidth,
    parameter int unsigned FWFT       = ModeStd,
    parameter int unsigned AF_THRESH  = (2 ** ADDR_WIDTH) - 2,
    parameter int unsigned AE_THRESH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  rd,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  al_full,
    output logic                  al_empty,
    output logic [ADDR_WIDTH:0]   wd_cnt,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned Depth  = 2 ** ADDR_WIDTH;
    localparam int unsigned CntW   = ADDR_WIDTH + 1;
    localparam bit          IsFwft = (FWFT == ModeFwft);

    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  afull_q, afull_d;
    logic                  aempty_q, aempty_d;
    logic                  rdv_q, rdv_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;

    logic                  rd_acc;
    logic                  wr_acc;
    logic                  rf_rd_en;
    logic [CntW-1:0]       mem_cnt;

    // Accept decisions. In FWFT the pop acknowledges the presented word, and the
    // output register is refilled whenever it is free or being popped and the
    // storage still holds words written at earlier edges.
    always_comb begin
        mem_cnt = cnt_q - CntW'(rdv_q);
        if (IsFwft) begin
            rd_acc   = rd & rdv_q & ~flush;
            rf_rd_en = ~flush & (mem_cnt != '0) & (~rdv_q | rd_acc);
        end else begin
            rd_acc   = rd & ~empty_q & ~flush;
            rf_rd_en = rd_acc;
        end
        wr_acc = wr & (~full_q | rd_acc) & ~flush;
    end

    // Next-state for pointers, count, flags and error bits.
    always_comb begin
        wptr_d = wptr_q + ADDR_WIDTH'(wr_acc);
        rptr_d = rptr_q + ADDR_WIDTH'(rf_rd_en);
        cnt_d  = cnt_q;
        unique case (cnt_op(wr_acc, rd_acc))
            OpWrite: cnt_d = cnt_q + CntW'(1);
            OpRead:  cnt_d = cnt_q - CntW'(1);
            OpIdle:  cnt_d = cnt_q;
            OpBoth:  cnt_d = cnt_q;
        endcase

        if (IsFwft) begin
            rdv_d = rf_rd_en | (rdv_q & ~rd_acc);
        end else begin
            rdv_d = rd_acc;
        end

        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
            rdv_d  = 1'b0;
        end

        full_d   = (cnt_d == CntW'(Depth));
        empty_d  = (cnt_d == '0);
        afull_d  = (cnt_d >= CntW'(AF_THRESH));
        aempty_d = (cnt_d <= CntW'(AE_THRESH));

        // Clear wins over a same-cycle set; a flush cycle raises no errors.
        ovf_d = ovf_q | (wr & full_q & ~rd & ~flush);
        udf_d = udf_q | (rd & empty_q & ~flush);
        if (clr_err) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            rdv_q    <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            rdv_q    <= rdv_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    reg_file_dp_param #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_reg_file (
        .clk_i    (clk),
        .rst_ni   (rst),
        .wr_en_i  (wr_acc),
        .wr_addr_i(wptr_q),
        .wr_data_i(data),
        .rd_en_i  (rf_rd_en),
        .rd_addr_i(rptr_q),
        .rd_data_o(rd_data)
    );

    assign rd_valid  = rdv_q;
    assign full      = full_q;
    assign empty     = empty_q;
    assign al_full   = afull_q;
    assign al_empty  = aempty_q;
    assign wd_cnt    = cnt_q;
    assign overflow  = ovf_q;
    assign underflow = udf_q;

endmodule
